// File: rtl/flow_pkg.sv
// Shared definitions for the byte/word flow converters (flow_8to16, flow_16to8).
package flow_pkg;

    localparam int W8  = 8;
    localparam int W16 = 16;

    // Which half of a word the first byte of a pair occupies.
    typedef enum logic {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } byte_order_e;

    localparam logic [W8-1:0] PAD_DEFAULT = 8'h00;

    // Combine the first and second byte of a pair into a word.
    function automatic logic [W16-1:0] pack_pair(input byte_order_e order,
                                                 input logic [W8-1:0] first,
                                                 input logic [W8-1:0] second);
        return (order == ORDER_LSB_FIRST) ? {second, first} : {first, second};
    endfunction

endpackage

// File: rtl/flow_out_reg.sv
// Generic valid-ready output register: load, hold, drain and back-to-back replace.
module flow_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              rdy,
    output logic              val,
    output logic [DATA_W-1:0] data
);

    // Load wins over drain so a consumed word can be replaced on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val  <= 1'b0;
            data <= '0;
        end else if (clr) begin
            val  <= 1'b0;
            data <= '0;
        end else if (load) begin
            val  <= 1'b1;
            data <= load_data;
        end else if (val && rdy) begin
            val  <= 1'b0;
        end
    end

endmodule

// File: rtl/flow_8to16.sv
// Packs a valid-ready byte flow into a valid-ready word flow; odd frame ends are padded.
module flow_8to16
    import flow_pkg::*;
#(
    parameter bit            LSB_FIRST = 1'b1,
    parameter logic [W8-1:0] PAD_BYTE  = PAD_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_en,
    input  logic           src_val,
    output logic           src_rdy,
    input  logic [W8-1:0]  src_data,
    input  logic           src_last,
    output logic           dst_val,
    input  logic           dst_rdy,
    output logic [W16-1:0] dst_data,
    output logic           dst_pad
);

    localparam byte_order_e ORDER = LSB_FIRST ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

    logic           half;
    logic [W8-1:0]  hold_q;
    logic           src_acc;
    logic           load;
    logic           clr;
    logic [W16:0]   load_word;
    logic [W16:0]   out_q;

    // A byte that completes a word needs the output slot free or draining this cycle.
    always_comb begin
        if (half)
            src_rdy = cfg_en & (~dst_val | dst_rdy);
        else
            src_rdy = cfg_en & (~dst_val | dst_rdy | ~src_last);
    end

    assign src_acc = src_val & src_rdy;
    assign load    = src_acc & (half | src_last);
    assign clr     = ~cfg_en;

    // Word to load: {pad flag, data}; a last byte at half=0 gets PAD_BYTE as its partner.
    always_comb begin
        if (half)
            load_word = {1'b0, pack_pair(ORDER, hold_q, src_data)};
        else
            load_word = {1'b1, pack_pair(ORDER, src_data, PAD_BYTE)};
    end

    // Pairing state; disabling discards any held first byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half   <= 1'b0;
            hold_q <= '0;
        end else if (!cfg_en) begin
            half   <= 1'b0;
        end else if (src_acc) begin
            if (half) begin
                half   <= 1'b0;
            end else if (!src_last) begin
                hold_q <= src_data;
                half   <= 1'b1;
            end
        end
    end

    flow_out_reg #(
        .DATA_W (W16 + 1)
    ) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_data (load_word),
        .rdy       (dst_rdy),
        .val       (dst_val),
        .data      (out_q)
    );

    assign dst_pad  = out_q[W16];
    assign dst_data = out_q[W16-1:0];

endmodule

// File: tb/tb_flow_8to16.sv
// Directed and randomised bench for flow_8to16 with both byte orders side by side.
module tb_flow_8to16;

    logic        clk = 1'b0;
    logic        rst_n, cfg_en, src_val, src_last, dst_rdy;
    logic [7:0]  src_data;
    logic        rdy_a, val_a, pad_a, rdy_b, val_b, pad_b;
    logic [15:0] data_a, data_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flow_8to16 #(.LSB_FIRST(1'b1), .PAD_BYTE(8'hEE)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
        .src_val(src_val), .src_rdy(rdy_a), .src_data(src_data), .src_last(src_last),
        .dst_val(val_a), .dst_rdy(dst_rdy), .dst_data(data_a), .dst_pad(pad_a)
    );

    flow_8to16 #(.LSB_FIRST(1'b0), .PAD_BYTE(8'hEE)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
        .src_val(src_val), .src_rdy(rdy_b), .src_data(src_data), .src_last(src_last),
        .dst_val(val_b), .dst_rdy(dst_rdy), .dst_data(data_b), .dst_pad(pad_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] da,
                           input logic [15:0] db, input logic p);
        chk({tag, " val_a"},  32'(val_a),  32'(v));
        chk({tag, " val_b"},  32'(val_b),  32'(v));
        chk({tag, " data_a"}, 32'(data_a), 32'(da));
        chk({tag, " data_b"}, 32'(data_b), 32'(db));
        chk({tag, " pad_a"},  32'(pad_a),  32'(p));
        chk({tag, " pad_b"},  32'(pad_b),  32'(p));
    endtask

    task automatic chk_rdy(input string tag, input logic r);
        chk({tag, " rdy_a"}, 32'(rdy_a), 32'(r));
        chk({tag, " rdy_b"}, 32'(rdy_b), 32'(r));
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        src_val  = v;
        src_data = d;
        src_last = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  bq[$];
    bit          lq[$];
    logic [16:0] ea[$], eb[$];
    logic [16:0] hold_a, hold_b;
    logic [7:0]  b0, b1;
    bit          sacc, dacc, stall;
    int          idx, wa, cyc, len;

    initial begin
        rst_n = 1'b0; cfg_en = 1'b1; dst_rdy = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick(); tick();
        chk_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        #1 chk_rdy("idle", 1'b1);

        // Streaming with dst_rdy high
        drive(1'b1, 8'h34, 1'b0); #1 chk_rdy("s0", 1'b1); tick();
        chk_out("s0", 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 8'h12, 1'b0); #1 chk_rdy("s1", 1'b1); tick();
        chk_out("s1", 1'b1, 16'h1234, 16'h3412, 1'b0);
        drive(1'b1, 8'h78, 1'b0); #1 chk_rdy("s2", 1'b1); tick();
        chk_out("s2", 1'b0, 16'h1234, 16'h3412, 1'b0);
        drive(1'b1, 8'h56, 1'b0); #1 chk_rdy("s3", 1'b1); tick();
        chk_out("s3", 1'b1, 16'h5678, 16'h7856, 1'b0);
        drive(1'b0, 8'h00, 1'b0); tick();
        chk_out("s4", 1'b0, 16'h5678, 16'h7856, 1'b0);

        // Back-pressure
        drive(1'b1, 8'h34, 1'b0); tick();
        drive(1'b1, 8'h12, 1'b0); tick();
        chk_out("bp0", 1'b1, 16'h1234, 16'h3412, 1'b0);
        dst_rdy = 1'b0;
        drive(1'b1, 8'h78, 1'b0); #1 chk_rdy("bp1", 1'b1); tick();
        chk_out("bp1", 1'b1, 16'h1234, 16'h3412, 1'b0);
        drive(1'b1, 8'h56, 1'b0); #1 chk_rdy("bp2", 1'b0); tick();
        chk_out("bp2", 1'b1, 16'h1234, 16'h3412, 1'b0);
        chk_rdy("bp3", 1'b0); tick();
        chk_out("bp3", 1'b1, 16'h1234, 16'h3412, 1'b0);
        dst_rdy = 1'b1; #1 chk_rdy("bp4", 1'b1); tick();
        chk_out("bp4", 1'b1, 16'h5678, 16'h7856, 1'b0);
        drive(1'b0, 8'h00, 1'b0); tick();
        chk_out("bp5", 1'b0, 16'h5678, 16'h7856, 1'b0);

        // Odd frame end, then confirm pairing restarts at a first byte
        drive(1'b1, 8'h9C, 1'b1); #1 chk_rdy("odd0", 1'b1); tick();
        chk_out("odd0", 1'b1, 16'hEE9C, 16'h9CEE, 1'b1);
        drive(1'b1, 8'h21, 1'b0); tick();
        chk_out("odd1", 1'b0, 16'hEE9C, 16'h9CEE, 1'b1);
        drive(1'b1, 8'h43, 1'b1); tick();
        chk_out("odd2", 1'b1, 16'h4321, 16'h2143, 1'b0);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Disable with a held byte and a pending word
        dst_rdy = 1'b0;
        drive(1'b1, 8'h34, 1'b0); tick();
        drive(1'b1, 8'h12, 1'b0); tick();
        drive(1'b1, 8'h78, 1'b0); tick();
        chk_out("dis0", 1'b1, 16'h1234, 16'h3412, 1'b0);
        drive(1'b0, 8'h00, 1'b0); cfg_en = 1'b0;
        #1 chk_rdy("dis1", 1'b0); tick();
        chk_out("dis1", 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_rdy("dis2", 1'b0);
        cfg_en = 1'b1; tick();
        dst_rdy = 1'b1;
        drive(1'b1, 8'h56, 1'b0); tick();
        chk_out("dis3", 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b1, 8'h9A, 1'b0); tick();
        chk_out("dis4", 1'b1, 16'h9A56, 16'h569A, 1'b0);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Asynchronous reset mid-pair with a word pending
        dst_rdy = 1'b0;
        drive(1'b1, 8'h34, 1'b0); tick();
        drive(1'b1, 8'h12, 1'b0); tick();
        drive(1'b1, 8'hA5, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("arst", 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        rst_n = 1'b1; dst_rdy = 1'b1;
        #1 chk_rdy("arst_rel", 1'b1);
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        chk_out("arst_pair", 1'b1, 16'h2211, 16'h1122, 1'b0);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Random frames: split model builds byte stream and the words it must pack into
        while (bq.size() < 10000) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) begin
                bq.push_back(8'($urandom));
                lq.push_back(i == len - 1);
            end
            for (int i = bq.size() - len; i < bq.size(); i += 2) begin
                b0 = bq[i];
                if (i + 1 < bq.size()) begin
                    b1 = bq[i + 1];
                    ea.push_back({1'b0, b1, b0});
                    eb.push_back({1'b0, b0, b1});
                end else begin
                    ea.push_back({1'b1, 8'hEE, b0});
                    eb.push_back({1'b1, b0, 8'hEE});
                end
            end
        end

        idx = 0; wa = 0; cyc = 0; stall = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        while ((idx < bq.size() || wa < ea.size()) && cyc < 60000) begin
            if (stall) begin
                chk("stall val_a", 32'(val_a), 32'd1);
                chk("stall data_a", 32'({pad_a, data_a}), 32'(hold_a));
                chk("stall data_b", 32'({pad_b, data_b}), 32'(hold_b));
            end
            if (!src_val && idx < bq.size())
                src_val = ($urandom_range(0, 3) != 0);
            if (src_val) begin
                src_data = bq[idx];
                src_last = lq[idx];
            end else begin
                src_data = 8'($urandom);
                src_last = 1'b0;
            end
            dst_rdy = ($urandom_range(0, 2) != 0);
            #1;
            sacc = src_val & rdy_a;
            dacc = val_a & dst_rdy;
            if (dacc) begin
                if (wa < ea.size()) begin
                    chk("rand word_a", 32'({pad_a, data_a}), 32'(ea[wa]));
                    chk("rand word_b", 32'({pad_b, data_b}), 32'(eb[wa]));
                    wa++;
                end else begin
                    chk("rand extra word", 32'(wa + 1), 32'(ea.size()));
                end
            end
            stall  = val_a & ~dst_rdy;
            hold_a = {pad_a, data_a};
            hold_b = {pad_b, data_b};
            tick();
            cyc++;
            if (sacc) begin
                idx++;
                src_val = 1'b0;
            end
        end
        chk("rand bytes consumed", 32'(idx), 32'(bq.size()));
        chk("rand words delivered", 32'(wa), 32'(ea.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_8to16.md
Name: flow_8to16

Overview:
- Packs an 8-bit valid-ready byte flow into a 16-bit valid-ready word flow.
- Receive-side counterpart of the 16-to-8 splitter: the byte order matches the splitter's output order, so a split-then-pack loop reproduces the original words.
- Sits between a byte-wide link and a word-wide consumer.
- Sustains 1 byte/cycle when dst_rdy is held high.

Parameters:
- LSB_FIRST, 1, 1: first byte of a pair goes to dst_data[7:0]; 0: first byte goes to dst_data[15:8].
- PAD_BYTE, 8'h00, value inserted in the missing half when a frame ends on an odd byte.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active low.
- cfg_en  input  1  enable, active high; protocol may be violated on disable.
- src_val  input  1  byte valid.
- src_rdy  output  1  byte ready.
- src_data  input  8  byte data, steady while src_val high and not accepted.
- src_last  input  1  marks the final byte of a frame; qualified by src_val.
- dst_val  output  1  word valid (registered).
- dst_rdy  input  1  word ready.
- dst_data  output  16  word data (registered), steady while dst_val high.
- dst_pad  output  1  word carries PAD_BYTE in its second half (registered).

Behaviour:
- Definitions: src_acc = src_val & src_rdy; dst_acc = dst_val & dst_rdy.
- State:
  - half (0 = waiting first byte, 1 = holding first byte).
  - hold_q[7:0]: stored first byte.
  - Output registers dst_val, dst_data, dst_pad.
- Reset (rst_n low, async): half=0, hold_q=0, dst_val=0, dst_data=0, dst_pad=0.
- src_rdy is combinational: src_rdy = cfg_en & (half==0 ? (~dst_val | dst_rdy | ~src_last) : (~dst_val | dst_rdy)).
  - A first byte without last is always accepted.
  - Any byte that completes a word needs the output slot free or draining this cycle.
- Accept with half=0, src_last=0: hold_q <= src_data; half <= 1. No output change except dst_acc clearing dst_val.
- Accept with half=1:
  - dst_data <= {src_data, hold_q} if LSB_FIRST, else {hold_q, src_data}.
  - dst_val <= 1; dst_pad <= 0; half <= 0.
  - src_last on this byte needs no special action.
- Accept with half=0, src_last=1 (odd frame end):
  - dst_data <= {PAD_BYTE, src_data} if LSB_FIRST, else {src_data, PAD_BYTE}.
  - dst_val <= 1; dst_pad <= 1; half stays 0.
- Latency: word-completing byte accepted at edge N → dst_val=1 and data visible after edge N.
- dst_val clears on dst_acc, unless a new word is loaded on the same edge. In that case dst_val stays 1 and the data is replaced (back-to-back).
- dst_data and dst_pad change only on a load, never while dst_val=1 without dst_acc.
- Throughput: with dst_rdy=1 constantly, one word every 2 cycles and src_rdy stays 1.
- Back-pressure:
  - With dst_val=1, dst_rdy=0, half=1: src_rdy=0. The second byte waits; hold_q is unchanged.
  - With dst_val=1, dst_rdy=0, half=0: a non-last byte is still accepted into hold_q.
- cfg_en low (synchronous, highest priority after reset): half<=0, dst_val<=0, dst_pad<=0, dst_data<=0, src_rdy=0. A held first byte is discarded.
- cfg_en rising: the block starts at half=0 the following cycle.
- src_last with half=1 and src_val: treated as an ordinary second byte (the frame is even).

Decomposition:
- Shared package (flow_pkg):
  - Byte/word width constants W8=8, W16=16.
  - Byte-order enum LSB_FIRST/MSB_FIRST, shared with flow_16to8.
  - Default pad constant.
- One natural sub-module, flow_out_reg: a generic valid-ready output register (load, hold, clear, back-to-back replace) with a width parameter. It is reused for dst_val/dst_data/dst_pad.
- The pairing logic stays in the top module.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-pair (half=1, hold_q=8'hA5) → all outputs 0 immediately.
  - After release with cfg_en=1, src_rdy=1 and half=0.
- Streaming:
  - cfg_en=1, dst_rdy=1, bytes 8'h34,8'h12,8'h78,8'h56 on consecutive cycles → dst_data 16'h1234 then 16'h5678, one cycle after each second byte; dst_pad=0; src_rdy never low.
  - LSB_FIRST=0 with the same stimulus → 16'h3412, 16'h7856.
- Back-pressure:
  - dst_rdy=0 after the first word → the next first byte is accepted, then src_rdy=0.
  - dst_data holds 16'h1234 steady.
  - When dst_rdy rises, 16'h1234 is accepted and 16'h5678 is loaded on the same edge; dst_val remains 1.
- Odd frame: byte 8'h9C with src_last=1 at half=0, PAD_BYTE=8'hEE → dst_data=16'hEE9C, dst_pad=1, half stays 0.
- Disable: cfg_en drops with half=1 and dst_val=1 → next cycle dst_val=0, dst_data=0, src_rdy=0, and the held byte is discarded. The byte after re-enable is treated as a first byte.
- Random: random src_val/dst_rdy over 10k bytes, compared against a split/pack scoreboard built with flow_16to8 → no loss, no duplication, and data stable while stalled.
